ddr_dqs_lane_trainer: RTL and testbench
=======================================

# ddr_dqs_lane_trainer

Parametrised per-lane DQS delay-line centring controller for the DDR4 PHY block. It drives the dynamic delay-line controls and eye-monitor clear of NUM_LANES DQS IOD lanes, scans each lane's tap range, and parks each lane at the centre of its clean eye window. It sits between the PHY training sequencer and the lane IOD wrappers, in the FAB_CLK domain.

## Interface
- NUM_LANES, 2, number of DQS lanes trained, sequentially from lane 0 upward
- TAP_W, 8, tap counter width; MAX_TAP = 2**TAP_W-1
- SETTLE_CYCLES, 4, idle cycles after any LOAD/MOVE before sampling (>=1)
- SAMPLE_CYCLES, 16, cycles the eye flags are observed per tap (>=1)

Ports:
- FAB_CLK  in  1  sole clock, rising edge
- ARST_N  in  1  reset; one clock, asynchronous assert, active-low
- START  in  1  one-cycle request; honoured only in IDLE or DONE
- BUSY  out  1  high from the cycle after an accepted START until DONE
- DONE  out  1  level; high after all lanes finish, cleared by next accepted START
- DELAY_LINE_LOAD  out  NUM_LANES  one-cycle pulse, resets the lane delay to tap 0
- DELAY_LINE_MOVE  out  NUM_LANES  one-cycle pulse, one tap step
- DELAY_LINE_DIRECTION  out  NUM_LANES  1 = increment, 0 = decrement; valid with MOVE
- DELAY_LINE_OUT_OF_RANGE  in  NUM_LANES  lane delay at its limit
- EYE_MONITOR_CLEAR_FLAGS  out  NUM_LANES  one-cycle pulse
- EYE_MONITOR_EARLY  in  NUM_LANES  sticky early flag
- EYE_MONITOR_LATE  in  NUM_LANES  sticky late flag
- TAP_OUT  out  NUM_LANES*TAP_W  final tap per lane, lane i at [i*TAP_W +: TAP_W]
- LANE_FAIL  out  NUM_LANES  lane found no clean tap or hit out-of-range

## Operation
- States: IDLE, LOAD, CLEAR, SETTLE, SAMPLE, EVAL, STEP, RETREAT, NEXT, DONE.
- IDLE/DONE + START: lane=0, clear TAP_OUT and LANE_FAIL, go LOAD.
- LOAD: pulse LOAD[lane]; tap=0, left/found flags cleared; go SETTLE.
- SETTLE: count SETTLE_CYCLES, then CLEAR.
- CLEAR: pulse CLEAR_FLAGS[lane]; go SAMPLE.
- SAMPLE: SAMPLE_CYCLES cycles; dirty |= EARLY[lane] | LATE[lane] on each cycle.
- EVAL: clean = !dirty.
  - No window yet, clean: left=tap, found=1.
  - Window open, dirty: right=tap-1; go RETREAT.
  - Clean and tap==MAX_TAP: right=MAX_TAP; go RETREAT.
  - Otherwise, if tap==MAX_TAP and no window: fail.
  - Otherwise: go STEP.
- STEP: pulse MOVE[lane] with DIRECTION=1, tap+=1; go SETTLE.
- RETREAT: centre=(left+right)>>1, computed at TAP_W+1 bits and floored. Issue (tap-centre) MOVE pulses with DIRECTION=0, one every 2 cycles. Then write TAP_OUT[lane]=centre and go NEXT.
- Fail: set LANE_FAIL[lane], pulse LOAD[lane], TAP_OUT[lane]=0, go NEXT.
- OUT_OF_RANGE[lane] sampled high in SETTLE, SAMPLE or STEP triggers fail at once; it takes priority over EVAL.
- NEXT: lane==NUM_LANES-1 goes DONE, else lane+=1 and go LOAD.
- Only the active lane's outputs ever pulse; all other bits stay 0.

## Timing
- Reset values: BUSY=0, DONE=0, all pulse outputs 0, DIRECTION=0, TAP_OUT=0, LANE_FAIL=0, state IDLE.
- START accepted on edge k: LOAD pulse visible in cycle k+1.
- Per scanned tap: 1 (STEP or LOAD) + SETTLE_CYCLES + 1 CLEAR + SAMPLE_CYCLES + 1 EVAL cycles.
- All outputs are registered; no input-to-output combinational path.
- START while BUSY is ignored.
- Reset mid-operation: everything returns to reset values immediately; the lane delay is not restored (the next START reloads it).

## Structure
- Package ddr_train_pkg: state enum, TAP_W-based tap typedef, direction constants DIR_INC/DIR_DEC.
- One sub-module, ddr_eye_sampler: the settle/sample counters and the dirty accumulator, with start, done and clean handshake signals.
- The FSM, lane index and the left/right/tap registers live in the top.

## Test plan
All scenarios use NUM_LANES=2, TAP_W=5, SETTLE=4, SAMPLE=16.
- Lane 0 clean on taps 10..20 -> 21 up-moves, then 6 down-moves; TAP_OUT[0]=15, LANE_FAIL=00, DONE high, BUSY low.
- Lane 1 clean on taps 25..31 -> no up-move past 31; 3 down-moves; TAP_OUT[1]=28.
- Lane 0 never clean -> 31 up-moves, then LOAD pulse; LANE_FAIL[0]=1, TAP_OUT[0]=0; lane 1 still trained.
- OUT_OF_RANGE[0] raised at tap 12 -> fail within 1 cycle; LOAD[0] pulses; LANE_FAIL=01.
- START pulsed while BUSY -> no restart. Then ARST_N low mid-SAMPLE -> all outputs at reset values in the same cycle; a new START completes normally.
- Single EARLY glitch at cycle 8 of tap 15's sample, window 10..20 -> right=14, centre=12, TAP_OUT[0]=12.

Source files
------------

// File: rtl/ddr_train_pkg.sv
// Shared definitions for the DQS lane trainer: FSM encodings, tap type, delay directions.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ddr_train_pkg;

    localparam int TAP_W_DEF = 8;
    typedef logic [TAP_W_DEF-1:0] tap_t;

    typedef logic [3:0] state_t;
    localparam state_t ST_IDLE    = 4'd0;
    localparam state_t ST_LOAD    = 4'd1;
    localparam state_t ST_CLEAR   = 4'd2;
    localparam state_t ST_SETTLE  = 4'd3;
    localparam state_t ST_SAMPLE  = 4'd4;
    localparam state_t ST_EVAL    = 4'd5;
    localparam state_t ST_STEP    = 4'd6;
    localparam state_t ST_RETREAT = 4'd7;
    localparam state_t ST_NEXT    = 4'd8;
    localparam state_t ST_DONE    = 4'd9;

    localparam logic DIR_INC = 1'b1;
    localparam logic DIR_DEC = 1'b0;

endpackage

// File: rtl/ddr_dqs_lane_trainer_if.sv
// Sequencer/IOD-facing signal bundle of the DQS lane trainer.
// Latency: n/a (wiring only).
// Backpressure: none; START is a one-cycle request, all pulses are fire-and-forget.
interface ddr_dqs_lane_trainer_if #(
    parameter int NUM_LANES = 2,
    parameter int TAP_W     = 8
);
    logic                       START;
    logic                       BUSY;
    logic                       DONE;
    logic [NUM_LANES-1:0]       DELAY_LINE_LOAD;
    logic [NUM_LANES-1:0]       DELAY_LINE_MOVE;
    logic [NUM_LANES-1:0]       DELAY_LINE_DIRECTION;
    logic [NUM_LANES-1:0]       DELAY_LINE_OUT_OF_RANGE;
    logic [NUM_LANES-1:0]       EYE_MONITOR_CLEAR_FLAGS;
    logic [NUM_LANES-1:0]       EYE_MONITOR_EARLY;
    logic [NUM_LANES-1:0]       EYE_MONITOR_LATE;
    logic [NUM_LANES*TAP_W-1:0] TAP_OUT;
    logic [NUM_LANES-1:0]       LANE_FAIL;

    modport master (
        output START, DELAY_LINE_OUT_OF_RANGE, EYE_MONITOR_EARLY, EYE_MONITOR_LATE,
        input  BUSY, DONE, DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION,
               EYE_MONITOR_CLEAR_FLAGS, TAP_OUT, LANE_FAIL
    );

    modport slave (
        input  START, DELAY_LINE_OUT_OF_RANGE, EYE_MONITOR_EARLY, EYE_MONITOR_LATE,
        output BUSY, DONE, DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION,
               EYE_MONITOR_CLEAR_FLAGS, TAP_OUT, LANE_FAIL
    );
endinterface

// File: rtl/ddr_eye_sampler.sv
// Settle/sample interval counter with a sticky dirty accumulator over the eye flag.
// Latency: done after SETTLE_CYCLES or SAMPLE_CYCLES cycles from the start cycle; clean valid the cycle after the last sample.
// Backpressure: none; a new start simply reloads the counter and abandons any interval in flight.
module ddr_eye_sampler #(
    parameter int SETTLE_CYCLES = 4,
    parameter int SAMPLE_CYCLES = 16
) (
    input  logic core_clk,
    input  logic arst_n,
    input  logic settle_start,
    input  logic sample_start,
    input  logic flag,
    output logic done,
    output logic clean
);
    localparam int MAX_CYC = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    logic [CNT_W-1:0] cnt;
    logic             run;
    logic             sampling;
    logic             dirty;

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt      <= '0;
            run      <= 1'b0;
            sampling <= 1'b0;
            dirty    <= 1'b0;
        end else if (settle_start) begin
            cnt      <= CNT_W'(SETTLE_CYCLES - 1);
            run      <= 1'b1;
            sampling <= 1'b0;
        end else if (sample_start) begin
            cnt      <= CNT_W'(SAMPLE_CYCLES - 1);
            run      <= 1'b1;
            sampling <= 1'b1;
            dirty    <= 1'b0;
        end else if (run) begin
            // The final sample cycle still folds its flag in before clean is read.
            if (sampling) dirty <= dirty | flag;
            if (cnt == '0) run <= 1'b0;
            else           cnt <= cnt - 1'b1;
        end
    end

    assign done  = run && (cnt == '0);
    assign clean = !dirty;

endmodule

// File: rtl/ddr_dqs_lane_trainer.sv
// Scans each DQS lane's delay taps upward, finds the first clean eye window and parks the lane at its centre.
// Latency: per tap 1+SETTLE_CYCLES+1+SAMPLE_CYCLES+1 cycles; LOAD pulse the cycle after an accepted START.
// Backpressure: none; START is ignored while BUSY, all outputs are registered one-cycle pulses or levels.
module ddr_dqs_lane_trainer
    import ddr_train_pkg::*;
#(
    parameter int NUM_LANES     = 2,
    parameter int TAP_W         = 8,
    parameter int SETTLE_CYCLES = 4,
    parameter int SAMPLE_CYCLES = 16
) (
    input  logic                  FAB_CLK,
    input  logic                  ARST_N,
    ddr_dqs_lane_trainer_if.slave lane_if
);
    localparam int                   LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [TAP_W-1:0]     MAX_TAP   = '1;
    localparam logic [NUM_LANES-1:0] LANE0     = NUM_LANES'(1);
    localparam logic [LANE_W-1:0]    LAST_LANE = LANE_W'(NUM_LANES - 1);

    state_t                     state;
    logic [LANE_W-1:0]          lane;
    logic [TAP_W-1:0]           tap, win_lo, win_hi, centre;
    logic [TAP_W:0]             span_sum;
    logic                       found, gap, busy_q, done_q;
    logic [NUM_LANES-1:0]       load_q, move_q, dir_q, clr_q, fail_q, lane_mask;
    logic [NUM_LANES*TAP_W-1:0] tap_out_q;
    logic                       oor_hit, eye_flag, smp_done, smp_clean, fail_now;

    assign lane_mask = LANE0 << lane;
    assign oor_hit   = lane_if.DELAY_LINE_OUT_OF_RANGE[lane];
    assign eye_flag  = lane_if.EYE_MONITOR_EARLY[lane] | lane_if.EYE_MONITOR_LATE[lane];
    // Widened so a window ending at MAX_TAP cannot overflow before the halving.
    assign span_sum  = {1'b0, win_lo} + {1'b0, win_hi};
    assign centre    = TAP_W'(span_sum >> 1);

    always_comb begin
        fail_now = 1'b0;
        if ((state == ST_SETTLE || state == ST_SAMPLE || state == ST_STEP) && oor_hit)
            fail_now = 1'b1;
        else if (state == ST_EVAL && !smp_clean && !found && tap == MAX_TAP)
            fail_now = 1'b1;
    end

    ddr_eye_sampler #(
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .SAMPLE_CYCLES (SAMPLE_CYCLES)
    ) u_sampler (
        .core_clk     (FAB_CLK),
        .arst_n       (ARST_N),
        .settle_start (state == ST_LOAD || state == ST_STEP),
        .sample_start (state == ST_CLEAR),
        .flag         (eye_flag),
        .done         (smp_done),
        .clean        (smp_clean)
    );

    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state     <= ST_IDLE;
            lane      <= '0;
            tap       <= '0;
            win_lo    <= '0;
            win_hi    <= '0;
            found     <= 1'b0;
            gap       <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            load_q    <= '0;
            move_q    <= '0;
            dir_q     <= '0;
            clr_q     <= '0;
            fail_q    <= '0;
            tap_out_q <= '0;
        end else begin
            load_q <= '0;
            move_q <= '0;
            clr_q  <= '0;
            if (fail_now) begin
                // Abandon the lane and return its delay line to a known tap.
                fail_q[lane]                          <= 1'b1;
                load_q                                <= lane_mask;
                tap_out_q[int'(lane)*TAP_W +: TAP_W] <= '0;
                state                                 <= ST_NEXT;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: if (lane_if.START) begin
                        lane      <= '0;
                        tap_out_q <= '0;
                        fail_q    <= '0;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        load_q    <= LANE0;
                        state     <= ST_LOAD;
                    end
                    ST_LOAD: begin
                        tap   <= '0;
                        found <= 1'b0;
                        state <= ST_SETTLE;
                    end
                    ST_SETTLE: if (smp_done) begin
                        clr_q <= lane_mask;
                        state <= ST_CLEAR;
                    end
                    ST_CLEAR:  state <= ST_SAMPLE;
                    ST_SAMPLE: if (smp_done) state <= ST_EVAL;
                    ST_EVAL: begin
                        if (smp_clean && !found) begin
                            win_lo <= tap;
                            found  <= 1'b1;
                        end
                        gap <= 1'b0;
                        if (found && !smp_clean) begin
                            win_hi <= tap - 1'b1;
                            state  <= ST_RETREAT;
                        end else if (smp_clean && tap == MAX_TAP) begin
                            win_hi <= MAX_TAP;
                            state  <= ST_RETREAT;
                        end else begin
                            move_q <= lane_mask;
                            dir_q  <= {NUM_LANES{DIR_INC}} & lane_mask;
                            state  <= ST_STEP;
                        end
                    end
                    ST_STEP: begin
                        tap   <= tap + 1'b1;
                        state <= ST_SETTLE;
                    end
                    ST_RETREAT: begin
                        // Alternate pulse/idle cycles so each down-move is a separate pulse.
                        if (gap) begin
                            gap <= 1'b0;
                        end else if (tap != centre) begin
                            move_q <= lane_mask;
                            dir_q  <= {NUM_LANES{DIR_DEC}} & lane_mask;
                            tap    <= tap - 1'b1;
                            gap    <= 1'b1;
                        end else begin
                            tap_out_q[int'(lane)*TAP_W +: TAP_W] <= centre;
                            state                                 <= ST_NEXT;
                        end
                    end
                    ST_NEXT: begin
                        if (lane == LAST_LANE) begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            lane   <= lane + 1'b1;
                            load_q <= LANE0 << (lane + 1'b1);
                            state  <= ST_LOAD;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign lane_if.BUSY                    = busy_q;
    assign lane_if.DONE                    = done_q;
    assign lane_if.DELAY_LINE_LOAD         = load_q;
    assign lane_if.DELAY_LINE_MOVE         = move_q;
    assign lane_if.DELAY_LINE_DIRECTION    = dir_q;
    assign lane_if.EYE_MONITOR_CLEAR_FLAGS = clr_q;
    assign lane_if.TAP_OUT                 = tap_out_q;
    assign lane_if.LANE_FAIL               = fail_q;

endmodule

// File: tb/tb_ddr_dqs_lane_trainer.sv
// Directed scenarios against a behavioural two-lane IOD/eye model; a scoreboard checks each completed training run.
module tb_ddr_dqs_lane_trainer;

    logic clk;
    logic arst_n;

    ddr_dqs_lane_trainer_if #(.NUM_LANES(2), .TAP_W(5)) ifc ();

    ddr_dqs_lane_trainer #(
        .NUM_LANES     (2),
        .TAP_W         (5),
        .SETTLE_CYCLES (4),
        .SAMPLE_CYCLES (16)
    ) dut (
        .FAB_CLK (clk),
        .ARST_N  (arst_n),
        .lane_if (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int tap0; int tap1; int fail;
        int up0;  int up1;  int dn0; int dn1;
        int ld0;  int ld1;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- IOD + eye monitor model ----------------
    int m_tap[2];
    int win_lo[2], win_hi[2], oor_tap[2], glitch_tap[2], glitch_cnt[2];
    logic [1:0] m_early, m_late, m_oor;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (ifc.DELAY_LINE_LOAD[i])      m_tap[i] = 0;
            else if (ifc.DELAY_LINE_MOVE[i]) m_tap[i] = ifc.DELAY_LINE_DIRECTION[i] ? m_tap[i] + 1 : m_tap[i] - 1;
            if (ifc.EYE_MONITOR_CLEAR_FLAGS[i]) begin
                m_early[i] = 1'b0;
                m_late[i]  = 1'b0;
                if (m_tap[i] == glitch_tap[i]) glitch_cnt[i] = 8;
            end
            if (m_tap[i] < win_lo[i]) m_early[i] = 1'b1;
            if (m_tap[i] > win_hi[i]) m_late[i]  = 1'b1;
            if (glitch_cnt[i] > 0) begin
                glitch_cnt[i]--;
                if (glitch_cnt[i] == 0) m_early[i] = 1'b1;
            end
            m_oor[i] = (m_tap[i] == oor_tap[i]);
        end
        ifc.EYE_MONITOR_EARLY       = m_early;
        ifc.EYE_MONITOR_LATE        = m_late;
        ifc.DELAY_LINE_OUT_OF_RANGE = m_oor;
    end

    // ---------------- Monitor / scoreboard ----------------
    int   up_cnt[2], dn_cnt[2], ld_cnt[2], multi_hot;
    logic busy_prev = 1'b0, done_prev = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (ifc.BUSY && !busy_prev) begin
            for (int i = 0; i < 2; i++) begin up_cnt[i] = 0; dn_cnt[i] = 0; ld_cnt[i] = 0; end
            multi_hot = 0;
        end
        for (int i = 0; i < 2; i++) begin
            if (ifc.DELAY_LINE_LOAD[i]) ld_cnt[i]++;
            if (ifc.DELAY_LINE_MOVE[i]) begin
                if (ifc.DELAY_LINE_DIRECTION[i]) up_cnt[i]++;
                else                             dn_cnt[i]++;
            end
        end
        if ($countones(ifc.DELAY_LINE_LOAD) > 1 || $countones(ifc.DELAY_LINE_MOVE) > 1 ||
            $countones(ifc.EYE_MONITOR_CLEAR_FLAGS) > 1)
            multi_hot++;
        if (ifc.DONE && !done_prev) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("tap_out0",  int'(ifc.TAP_OUT[4:0]), e.tap0);
                chk("tap_out1",  int'(ifc.TAP_OUT[9:5]), e.tap1);
                chk("lane_fail", int'(ifc.LANE_FAIL),    e.fail);
                chk("up_moves0", up_cnt[0], e.up0);
                chk("up_moves1", up_cnt[1], e.up1);
                chk("dn_moves0", dn_cnt[0], e.dn0);
                chk("dn_moves1", dn_cnt[1], e.dn1);
                chk("loads0",    ld_cnt[0], e.ld0);
                chk("loads1",    ld_cnt[1], e.ld1);
                chk("busy_at_done", int'(ifc.BUSY), 0);
                chk("multi_lane_pulse", multi_hot, 0);
            end
        end
        busy_prev = ifc.BUSY;
        done_prev = ifc.DONE;
    end

    // ---------------- Stimulus ----------------
    function automatic int out_vec();
        return int'({ifc.BUSY, ifc.DONE, ifc.DELAY_LINE_LOAD, ifc.DELAY_LINE_MOVE,
                     ifc.DELAY_LINE_DIRECTION, ifc.EYE_MONITOR_CLEAR_FLAGS,
                     ifc.TAP_OUT, ifc.LANE_FAIL});
    endfunction

    task automatic cfg(input int lo0, input int hi0, input int lo1, input int hi1,
                       input int oor0, input int gl0);
        win_lo[0] = lo0; win_hi[0] = hi0; win_lo[1] = lo1; win_hi[1] = hi1;
        oor_tap[0] = oor0; oor_tap[1] = -1; glitch_tap[0] = gl0; glitch_tap[1] = -1;
    endtask

    task automatic do_start();
        @(negedge clk); ifc.START = 1'b1;
        @(negedge clk); ifc.START = 1'b0;
        chk("load_after_start", int'(ifc.DELAY_LINE_LOAD), 1);
        chk("busy_after_start", int'(ifc.BUSY), 1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!ifc.DONE && n < 5000) begin @(negedge clk); n++; end
        if (!ifc.DONE) begin
            chk("done_timeout", 0, 1);
            if (exp_q.size() > 0) void'(exp_q.pop_back());
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic run(input exp_t e);
        exp_q.push_back(e);
        do_start();
        wait_done();
    endtask

    initial begin
        exp_t e;
        int   n;
        ifc.START = 1'b0;
        for (int i = 0; i < 2; i++) begin m_tap[i] = 0; glitch_cnt[i] = 0; end
        m_early = '0; m_late = '0; m_oor = '0;
        ifc.EYE_MONITOR_EARLY = '0; ifc.EYE_MONITOR_LATE = '0; ifc.DELAY_LINE_OUT_OF_RANGE = '0;
        cfg(10, 20, 25, 31, -1, -1);
        arst_n = 1'b0;
        #3;
        chk("reset_outputs", out_vec(), 0);
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_outputs", out_vec(), 0);

        // S1: window 10..20 / 25..31
        e = '{tap0:15, tap1:28, fail:0, up0:21, up1:31, dn0:6, dn1:3, ld0:1, ld1:1};
        run(e);

        // S2: lane 0 never clean
        cfg(99, -1, 25, 31, -1, -1);
        e = '{tap0:0, tap1:28, fail:1, up0:31, up1:31, dn0:0, dn1:3, ld0:2, ld1:1};
        run(e);

        // S3: out-of-range on lane 0 at tap 12; lane 1 window 3..7
        cfg(10, 20, 3, 7, 12, -1);
        e = '{tap0:0, tap1:5, fail:1, up0:12, up1:8, dn0:0, dn1:3, ld0:2, ld1:1};
        exp_q.push_back(e);
        do_start();
        n = 0;
        do begin @(posedge clk); n++; end while (!ifc.DELAY_LINE_OUT_OF_RANGE[0] && n < 2000);
        @(negedge clk);
        chk("oor_load_pulse", int'(ifc.DELAY_LINE_LOAD), 1);
        chk("oor_lane_fail",  int'(ifc.LANE_FAIL), 1);
        wait_done();

        // S4: early glitch at tap 15; lane 1 clean everywhere
        cfg(10, 20, 0, 31, -1, 15);
        e = '{tap0:12, tap1:15, fail:0, up0:15, up1:31, dn0:3, dn1:16, ld0:1, ld1:1};
        run(e);

        // S5: single-tap windows at both ends, START while busy ignored
        cfg(0, 0, 31, 31, -1, -1);
        e = '{tap0:0, tap1:31, fail:0, up0:1, up1:31, dn0:1, dn1:0, ld0:1, ld1:1};
        exp_q.push_back(e);
        do_start();
        repeat (40) @(negedge clk);
        ifc.START = 1'b1;
        @(negedge clk);
        ifc.START = 1'b0;
        chk("busy_after_restart", int'(ifc.BUSY), 1);
        wait_done();

        // S6: reset in the middle of a sample interval, then a clean rerun
        cfg(10, 20, 25, 31, -1, -1);
        do_start();
        n = 0;
        for (int k = 0; k < 3; k++) begin
            do begin @(negedge clk); n++; end while (!ifc.EYE_MONITOR_CLEAR_FLAGS[0] && n < 500);
        end
        repeat (5) @(negedge clk);
        #2 arst_n = 1'b0;
        #1;
        chk("midrun_reset_outputs", out_vec(), 0);
        chk("midrun_reset_busy", int'(ifc.BUSY), 0);
        @(negedge clk);
        arst_n = 1'b1;
        repeat (2) @(negedge clk);
        e = '{tap0:15, tap1:28, fail:0, up0:21, up1:31, dn0:6, dn1:3, ld0:1, ld1:1};
        run(e);

        chk("pending_expectations", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
